// File: rtl/settings_bus_arbiter.sv
// Round-robin settings-bus arbiter: atomic bursts per requester, optional
// inter-strobe gap and a watchdog that releases an owner that stops writing.
module settings_bus_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned GAP     = 0,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [8*NUM_REQ-1:0]  req_addr,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  set_stb,
  output logic [7:0]            set_addr,
  output logic [31:0]           set_data,
  output logic [1:0]            owner,
  output logic                  owner_vld,
  output logic                  timeout_evt
);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

  state_t      state, state_nx;
  logic [3:0]  gap_cnt;
  logic [9:0]  wd_cnt;
  logic        burst_done;

  logic        cur_valid, cur_last;
  logic [7:0]  cur_addr;
  logic [31:0] cur_data;
  logic [1:0]  winner;
  logic        found;
  logic        any_valid;
  logic        xfer, wd_fire, gap_end;

  // Owner-selected request fields; compare-based so narrow NUM_REQ needs no index casts
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_addr  = '0;
    cur_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == 2'(i)) begin
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        cur_addr  = req_addr[8*i +: 8];
        cur_data  = req_data[32*i +: 32];
      end
    end
  end

  // First valid requester searching upward from owner+1; the last owner is checked last
  always_comb begin
    winner = owner;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req_valid[j] && (j == (32'(owner) + k) % NUM_REQ)) begin
          winner = 2'(j);
          found  = 1'b1;
        end
      end
    end
  end

  assign any_valid = |req_valid;
  assign xfer      = (state == S_OWN) && cur_valid;
  assign wd_fire   = (TIMEOUT != 0) && (state == S_OWN) && !cur_valid &&
                     (wd_cnt == 10'(TIMEOUT - 1));
  assign gap_end   = (gap_cnt == 4'(GAP - 1));

  always_comb begin
    req_ready = '0;
    if (state == S_OWN) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (owner == 2'(i)) req_ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (any_valid) state_nx = S_OWN;
      S_OWN: begin
        if (xfer) begin
          if (GAP > 0)       state_nx = S_GAP;
          else if (cur_last) state_nx = S_IDLE;
          else               state_nx = S_OWN;
        end else if (wd_fire) begin
          state_nx = S_IDLE;
        end
      end
      S_GAP: if (gap_end) state_nx = burst_done ? S_IDLE : S_OWN;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_stb     <= 1'b0;
      set_addr    <= '0;
      set_data    <= '0;
      owner       <= 2'(NUM_REQ - 1);
      owner_vld   <= 1'b0;
      timeout_evt <= 1'b0;
      gap_cnt     <= '0;
      wd_cnt      <= '0;
      burst_done  <= 1'b0;
    end else begin
      set_stb     <= xfer;
      timeout_evt <= wd_fire;
      if (state == S_IDLE && any_valid) begin
        owner     <= winner;
        owner_vld <= 1'b1;
      end
      if (xfer) begin
        set_addr   <= cur_addr;
        set_data   <= cur_data;
        burst_done <= cur_last;
        if (cur_last) owner_vld <= 1'b0;
      end
      if (wd_fire) owner_vld <= 1'b0;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 4'd1 : '0;
      if ((TIMEOUT != 0) && (state == S_OWN) && !cur_valid && !wd_fire)
        wd_cnt <= wd_cnt + 10'd1;
      else
        wd_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_settings_bus_arbiter.sv
// Directed bench for settings_bus_arbiter: one instance with no gap and an
// 8-cycle watchdog, one with GAP=3; both share the requester stimulus.
module tb_settings_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  valid = '0;
  logic [2:0]  last = '0;
  logic [23:0] addr = '0;
  logic [95:0] data = '0;

  logic [2:0]  m_ready, g_ready;
  logic        m_stb, g_stb, m_ov, g_ov, m_evt, g_evt;
  logic [7:0]  m_addr, g_addr;
  logic [31:0] m_data, g_data;
  logic [1:0]  m_own, g_own;

  logic        sel = 1'b0;
  logic [2:0]  rdy;
  logic        stb, ov, evt;
  logic [7:0]  saddr;
  logic [31:0] sdata;

  assign rdy   = sel ? g_ready : m_ready;
  assign stb   = sel ? g_stb   : m_stb;
  assign ov    = sel ? g_ov    : m_ov;
  assign evt   = sel ? g_evt   : m_evt;
  assign saddr = sel ? g_addr  : m_addr;
  assign sdata = sel ? g_data  : m_data;

  always #5 clk = ~clk;

  settings_bus_arbiter #(.NUM_REQ(3), .GAP(0), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(valid), .req_last(last),
    .req_addr(addr), .req_data(data), .req_ready(m_ready),
    .set_stb(m_stb), .set_addr(m_addr), .set_data(m_data),
    .owner(m_own), .owner_vld(m_ov), .timeout_evt(m_evt));

  settings_bus_arbiter #(.NUM_REQ(3), .GAP(3), .TIMEOUT(0)) u_gap (
    .clk(clk), .rst_n(rst_n), .req_valid(valid), .req_last(last),
    .req_addr(addr), .req_data(data), .req_ready(g_ready),
    .set_stb(g_stb), .set_addr(g_addr), .set_data(g_data),
    .owner(g_own), .owner_vld(g_ov), .timeout_evt(g_evt));

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          rem[3];
  int          idx[3];
  logic [7:0]  base[3];
  logic [31:0] dbase[3];
  bit          cont[3];
  bit          nolast[3];
  logic [2:0]  rdy_log[64];
  logic        ov_log[64];
  logic        evt_log[64];
  logic [7:0]  s_addr[$];
  logic [31:0] s_data[$];
  int          s_cyc[$];

  task automatic drive_all();
    for (int i = 0; i < 3; i++) begin
      if (rem[i] > 0) begin
        valid[i]         = 1'b1;
        addr[8*i +: 8]   = base[i] + 8'(idx[i]);
        data[32*i +: 32] = dbase[i] + 32'(idx[i]);
        last[i]          = !nolast[i] && (rem[i] == 1);
      end else begin
        valid[i] = 1'b0;
        last[i]  = 1'b0;
      end
    end
  endtask

  task automatic rec();
    if (cyc < 64) begin
      rdy_log[cyc] = rdy;
      ov_log[cyc]  = ov;
      evt_log[cyc] = evt;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0; idx[i] = 0; base[i] = 8'(16 * i);
      dbase[i] = 32'h1000_0000 * 32'(i + 1);
      cont[i] = 1'b0; nolast[i] = 1'b0;
    end
    for (int c = 0; c < 64; c++) begin
      rdy_log[c] = 'x; ov_log[c] = 1'bx; evt_log[c] = 1'bx;
    end
    s_addr.delete(); s_data.delete(); s_cyc.delete();
    cyc = 0;
    drive_all();
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    drive_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    rec();
  endtask

  task automatic step();
    logic [2:0] acc;
    acc = valid & rdy;
    @(posedge clk);
    #1;
    cyc++;
    rec();
    if (stb) begin
      s_addr.push_back(saddr); s_data.push_back(sdata); s_cyc.push_back(cyc);
    end
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        idx[i]++;
        rem[i]--;
        if (rem[i] == 0 && cont[i]) rem[i] = 1;
      end
    end
    drive_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (m_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got=%b want=0", m_stb); end
    checks++; if (m_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h want=00", m_addr); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h want=0", m_data); end
    checks++; if (m_own !== 2'd2) begin errors++; $display("FAIL reset_owner got=%0d want=2", m_own); end
    checks++; if (m_ov !== 1'b0 || m_evt !== 1'b0) begin errors++; $display("FAIL reset_vld_evt got=%b%b want=00", m_ov, m_evt); end
    checks++; if (m_ready !== 3'b000 || g_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b/%b want=000", m_ready, g_ready); end
  endtask

  task automatic test_single();
    apply_reset();
    rem[0] = 1; base[0] = 8'h12; dbase[0] = 32'hDEAD_BEEF;
    release_reset();
    run(8);
    checks++; if (rdy_log[0] !== 3'b000) begin errors++; $display("FAIL single_arb_ready got=%b want=000", rdy_log[0]); end
    checks++; if (rdy_log[1] !== 3'b001) begin errors++; $display("FAIL single_ready got=%b want=001", rdy_log[1]); end
    checks++; if (ov_log[1] !== 1'b1 || ov_log[2] !== 1'b0) begin errors++; $display("FAIL single_owner_vld got=%b%b want=10", ov_log[1], ov_log[2]); end
    checks++; if (s_cyc.size() !== 1) begin errors++; $display("FAIL single_count got=%0d want=1", s_cyc.size()); end
    else begin
      checks++; if (s_cyc[0] !== 2) begin errors++; $display("FAIL single_latency got=%0d want=2", s_cyc[0]); end
      checks++; if (s_addr[0] !== 8'h12 || s_data[0] !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL single_payload got=%h/%h want=12/deadbeef", s_addr[0], s_data[0]); end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    rem[0] = 1; rem[2] = 1;
    release_reset();
    run(6);
    checks++; if (s_cyc.size() !== 2) begin errors++; $display("FAIL rr_pair_count got=%0d want=2", s_cyc.size()); end
    else begin
      checks++; if (s_addr[0] !== 8'h00 || s_addr[1] !== 8'h20) begin
        errors++; $display("FAIL rr_pair_order got=%h,%h want=00,20", s_addr[0], s_addr[1]); end
    end
    s_addr.delete(); s_data.delete(); s_cyc.delete();
    for (int i = 0; i < 3; i++) begin rem[i] = 1; idx[i] = 0; cont[i] = 1'b1; end
    drive_all();
    run(14);
    checks++; if (s_addr.size() < 6) begin errors++; $display("FAIL rr_cont_count got=%0d want>=6", s_addr.size()); end
    else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (s_addr[k][7:4] !== 4'(k % 3)) begin
          errors++; $display("FAIL rr_cont_owner[%0d] got=%0d want=%0d", k, s_addr[k][7:4], k % 3);
        end
      end
    end
  endtask

  task automatic test_burst();
    apply_reset();
    rem[1] = 3; base[1] = 8'h20;
    release_reset();
    step();
    rem[0] = 1; base[0] = 8'h00;
    drive_all();
    run(7);
    checks++; if (s_cyc.size() !== 4) begin errors++; $display("FAIL burst_count got=%0d want=4", s_cyc.size()); end
    else begin
      checks++; if (s_addr[0] !== 8'h20 || s_addr[1] !== 8'h21 || s_addr[2] !== 8'h22 || s_addr[3] !== 8'h00) begin
        errors++; $display("FAIL burst_order got=%h,%h,%h,%h want=20,21,22,00", s_addr[0], s_addr[1], s_addr[2], s_addr[3]); end
      checks++; if (s_cyc[0] !== 2 || s_cyc[1] !== 3 || s_cyc[2] !== 4 || s_cyc[3] !== 6) begin
        errors++; $display("FAIL burst_timing got=%0d,%0d,%0d,%0d want=2,3,4,6", s_cyc[0], s_cyc[1], s_cyc[2], s_cyc[3]); end
    end
  endtask

  task automatic test_gap();
    apply_reset();
    sel = 1'b1;
    rem[0] = 2; base[0] = 8'h30;
    release_reset();
    run(10);
    checks++; if (rdy_log[1] !== 3'b001) begin errors++; $display("FAIL gap_first_ready got=%b want=001", rdy_log[1]); end
    for (int c = 2; c <= 4; c++) begin
      checks++; if (rdy_log[c] !== 3'b000) begin errors++; $display("FAIL gap_hold[%0d] got=%b want=000", c, rdy_log[c]); end
    end
    checks++; if (rdy_log[5] !== 3'b001) begin errors++; $display("FAIL gap_resume got=%b want=001", rdy_log[5]); end
    checks++; if (s_cyc.size() !== 2) begin errors++; $display("FAIL gap_count got=%0d want=2", s_cyc.size()); end
    else begin
      checks++; if (s_cyc[0] !== 2 || s_cyc[1] !== 6) begin errors++; $display("FAIL gap_spacing got=%0d,%0d want=2,6", s_cyc[0], s_cyc[1]); end
      checks++; if (s_addr[1] !== 8'h31) begin errors++; $display("FAIL gap_addr got=%h want=31", s_addr[1]); end
    end
    sel = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset();
    rem[0] = 1; nolast[0] = 1'b1; base[0] = 8'h40;
    rem[1] = 1; base[1] = 8'h10;
    release_reset();
    run(14);
    checks++; if (evt_log[9] !== 1'b0 || evt_log[10] !== 1'b1 || evt_log[11] !== 1'b0) begin
      errors++; $display("FAIL to_pulse got=%b%b%b want=010", evt_log[9], evt_log[10], evt_log[11]); end
    checks++; if (ov_log[9] !== 1'b1 || ov_log[10] !== 1'b0) begin
      errors++; $display("FAIL to_owner_vld got=%b%b want=10", ov_log[9], ov_log[10]); end
    checks++; if (rdy_log[11] !== 3'b010) begin errors++; $display("FAIL to_next_grant got=%b want=010", rdy_log[11]); end
    checks++; if (s_cyc.size() !== 2) begin errors++; $display("FAIL to_count got=%0d want=2", s_cyc.size()); end
    else begin
      checks++; if (s_addr[0] !== 8'h40 || s_addr[1] !== 8'h10 || s_cyc[1] !== 12) begin
        errors++; $display("FAIL to_strobes got=%h,%h@%0d want=40,10@12", s_addr[0], s_addr[1], s_cyc[1]); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    rem[1] = 5; base[1] = 8'h50;
    release_reset();
    run(3);
    checks++; if (m_ready !== 3'b010 || m_stb !== 1'b1) begin
      errors++; $display("FAIL ar_midburst got=%b/%b want=010/1", m_ready, m_stb); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (m_stb !== 1'b0 || m_ready !== 3'b000 || m_ov !== 1'b0) begin
      errors++; $display("FAIL ar_drop got=%b/%b/%b want=0/000/0", m_stb, m_ready, m_ov); end
    apply_reset();
    rem[0] = 1; base[0] = 8'h60;
    rem[1] = 5; base[1] = 8'h50;
    release_reset();
    run(3);
    checks++; if (rdy_log[1] !== 3'b001) begin errors++; $display("FAIL ar_restart got=%b want=001", rdy_log[1]); end
    checks++; if (s_addr.size() < 1) begin errors++; $display("FAIL ar_first_count got=%0d want>=1", s_addr.size()); end
    else begin
      checks++; if (s_addr[0] !== 8'h60) begin errors++; $display("FAIL ar_first_addr got=%h want=60", s_addr[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_gap();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/settings_bus_arbiter.md
Name: settings_bus_arbiter

Overview:
- Shares the single 8-bit-address / 32-bit-data settings bus (strobe, addr, data) between up to 4 requesters, e.g. the wishbone bridge, the UDP control-packet engine and the firmware sequencer.
- Grants are round-robin. Each grant is held as an atomic burst until the requester marks its last write, so multi-register configuration sequences are never interleaved.
- A programmable gap enforces a minimum spacing between strobes. A watchdog releases a stalled owner.

Parameters:
NUM_REQ, 3, number of requesters (legal 2..4)
GAP, 0, idle cycles forced after every strobe before the next accept (0..15)
TIMEOUT, 255, cycles an owner may hold the grant with req_valid low before forced release (0 = watchdog disabled; max 1023)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  requester i has a write pending
req_last  input  NUM_REQ  write presented by requester i is the last of its burst
req_addr  input  8*NUM_REQ  requester i address, slice [8i+7:8i]
req_data  input  32*NUM_REQ  requester i data, slice [32i+31:32i]
req_ready  output  NUM_REQ  write from requester i accepted this cycle when valid&ready
set_stb  output  1  settings bus strobe
set_addr  output  8  settings bus address
set_data  output  32  settings bus data
owner  output  2  index of current/last grantee
owner_vld  output  1  a grant is currently held
timeout_evt  output  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (async assert, sync release):
  - set_stb=0, set_addr=0, set_data=0.
  - owner=NUM_REQ-1 (so requester 0 wins first), owner_vld=0, timeout_evt=0.
  - State IDLE; gap and watchdog counters 0.
  - Reset mid-burst abandons the burst; nothing partial is replayed.
- States: IDLE, OWN, GAP.
- IDLE:
  - If any req_valid, the winner is the first asserted index searching from (owner+1) mod NUM_REQ upward with wrap.
  - Next edge: owner=winner, owner_vld=1, go to OWN.
  - No accept happens in the arbitration cycle.
- OWN:
  - req_ready[owner] = (state==OWN); all other ready bits are 0. Ready is decoded from registers only; no combinational path from req_valid.
  - Transfer when req_valid[owner]&req_ready[owner]. Next cycle: set_stb=1, set_addr/set_data = captured values (registered, one-cycle latency).
  - set_stb is high for exactly one cycle per transfer. set_addr/set_data hold their last value while set_stb=0.
  - After a transfer with req_last=0: go to GAP if GAP>0, else stay in OWN (back-to-back, one write per cycle).
  - After a transfer with req_last=1: owner_vld clears. Go to GAP if GAP>0, else IDLE.
- GAP:
  - All ready bits low; counts GAP cycles.
  - Then returns to OWN if the burst is unfinished, else to IDLE.
- Watchdog (TIMEOUT>0):
  - Counts consecutive OWN cycles with req_valid[owner]=0; the counter clears on any transfer.
  - On reaching TIMEOUT: timeout_evt=1 for one cycle, owner_vld=0, state IDLE. No strobe is issued.
- Fairness: a released owner is lowest priority in the next arbitration. A requester with valid held never waits more than NUM_REQ-1 bursts.
- Requesters must hold addr/data/last stable while valid and not ready. Dropping valid before acceptance is legal; in OWN it only feeds the watchdog.
- Requester indices >= NUM_REQ do not exist. owner never takes such a value.

Test Plan:
- Reset release, req0 single write addr=0x12 data=0xDEADBEEF last=1, GAP=0:
  - arbitration at T, req_ready[0] at T+1, set_stb at T+2 with 0x12/0xDEADBEEF.
  - owner_vld low after T+1; exactly one strobe.
- req0 and req2 both valid from reset, each 1-write burst:
  - strobes ordered req0 then req2.
  - Then req0, req1, req2 all continuously requesting: strobe sequence owners 0,1,2,0,… round-robin.
- req1 burst of 3 writes (0x20,0x21,0x22, last on third) while req0 requests mid-burst:
  - three consecutive req1 strobes with no interleaving; req0 strobe follows.
- GAP=3, burst of 2 writes: exactly 3 cycles with all ready low after the first accept; strobes 4 cycles apart.
- TIMEOUT=8: req0 asserts one write with last=0, then drops valid:
  - timeout_evt pulses on the 8th idle cycle; owner_vld=0.
  - Pending req1 is granted next; no spurious strobe.
- rst_n asserted asynchronously between edges mid-burst:
  - set_stb and all ready bits drop immediately.
  - After release, arbitration restarts with requester 0 first.
